// File: rtl/daq_converter_responder.sv
// Converter-side SPI engine: turns DAC/ADC request edges into one serial transfer each
// and answers with a one-cycle done pulse (plus the captured word for ADC reads).
module daq_converter_responder #(
   parameter int DATA_W   = 12,
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dac_en_i,
   input  logic [DATA_W-1:0] dac_data_i,
   output logic              dac_done_o,
   input  logic              adc_en_i,
   output logic [DATA_W-1:0] adc_data_o,
   output logic              adc_done_o,
   output logic              busy_o,
   output logic              sclk_o,
   output logic              mosi_o,
   output logic              dac_cs_n_o,
   output logic              adc_cs_n_o,
   input  logic              miso_i
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int SET_W = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(CS_SETUP - 1);

   typedef enum logic [2:0] {
      IDLE, DAC_SETUP, ADC_SETUP, DAC_SHIFT, ADC_SHIFT, DONE
   } state_t;

   state_t            state, state_next;
   logic              dac_en_q, adc_en_q;
   logic              dac_rise, adc_rise;
   logic [DIV_W-1:0]  div_cnt;
   logic              high_half;
   logic [BIT_W-1:0]  bit_cnt;
   logic [SET_W-1:0]  setup_cnt;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] adc_data;
   logic              done_is_dac;
   logic              setup_last, half_last, shift_last;

   assign dac_rise   = dac_en_i & ~dac_en_q;
   assign adc_rise   = adc_en_i & ~adc_en_q;
   assign setup_last = (setup_cnt == SET_LAST);
   assign half_last  = (div_cnt == DIV_LAST);
   assign shift_last = half_last && !high_half && (bit_cnt == BIT_LAST);
   assign adc_data_o = adc_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Outputs decode from registered state only, so an async reset releases cs_n at once.
   always_comb begin
      state_next = state;
      dac_done_o = 1'b0;
      adc_done_o = 1'b0;
      busy_o     = 1'b1;
      sclk_o     = 1'b0;
      mosi_o     = 1'b0;
      dac_cs_n_o = 1'b1;
      adc_cs_n_o = 1'b1;
      case (state)
         IDLE: begin
            busy_o = 1'b0;
            if (dac_rise)      state_next = DAC_SETUP;
            else if (adc_rise) state_next = ADC_SETUP;
         end
         DAC_SETUP: begin
            dac_cs_n_o = 1'b0;
            mosi_o     = shift_reg[DATA_W-1];
            if (setup_last) state_next = DAC_SHIFT;
         end
         ADC_SETUP: begin
            adc_cs_n_o = 1'b0;
            if (setup_last) state_next = ADC_SHIFT;
         end
         DAC_SHIFT: begin
            dac_cs_n_o = 1'b0;
            sclk_o     = high_half;
            mosi_o     = shift_reg[DATA_W-1];
            if (shift_last) state_next = DONE;
         end
         ADC_SHIFT: begin
            adc_cs_n_o = 1'b0;
            sclk_o     = high_half;
            if (shift_last) state_next = DONE;
         end
         DONE: begin
            dac_done_o = done_is_dac;
            adc_done_o = ~done_is_dac;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dac_en_q    <= 1'b0;
         adc_en_q    <= 1'b0;
         div_cnt     <= '0;
         high_half   <= 1'b1;
         bit_cnt     <= '0;
         setup_cnt   <= '0;
         shift_reg   <= '0;
         adc_data    <= '0;
         done_is_dac <= 1'b0;
      end else begin
         dac_en_q <= dac_en_i;
         adc_en_q <= adc_en_i;
         case (state)
            IDLE: begin
               div_cnt   <= '0;
               high_half <= 1'b1;
               bit_cnt   <= '0;
               setup_cnt <= '0;
               if (dac_rise) begin
                  shift_reg   <= dac_data_i;
                  done_is_dac <= 1'b1;
               end else if (adc_rise) begin
                  shift_reg   <= '0;
                  done_is_dac <= 1'b0;
               end
            end
            DAC_SETUP, ADC_SETUP: setup_cnt <= setup_cnt + 1'b1;
            DAC_SHIFT, ADC_SHIFT: begin
               div_cnt <= half_last ? '0 : div_cnt + 1'b1;
               if (half_last) begin
                  high_half <= ~high_half;
                  if (!high_half && bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + 1'b1;
               end
               // DAC advances on the falling edge; the final bit stays on mosi to the end
               if (state == DAC_SHIFT && half_last && high_half && bit_cnt != BIT_LAST)
                  shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
               if (state == ADC_SHIFT && high_half && div_cnt == '0)
                  shift_reg <= {shift_reg[DATA_W-2:0], miso_i};
               if (state == ADC_SHIFT && shift_last)
                  adc_data <= shift_reg;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_daq_converter_responder.sv
// Randomised self-checking bench: an SPI slave model feeds miso, a monitor records
// sclk/mosi/done activity, and each transfer is checked against latency/bit rules.
module tb_daq_converter_responder;
   localparam int DATA_W   = 12;
   localparam int CLK_DIV  = 4;
   localparam int CS_SETUP = 2;
   localparam int LAT      = 1 + CS_SETUP + 2 * DATA_W * CLK_DIV;

   logic              clk = 1'b0;
   logic              reset;
   logic              dac_en_i, adc_en_i;
   logic [DATA_W-1:0] dac_data_i;
   logic              dac_done, adc_done, busy, sclk, mosi, dac_cs_n, adc_cs_n, miso;
   logic [DATA_W-1:0] adc_data_o;

   daq_converter_responder #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP)) dut (
      .clk(clk), .reset(reset),
      .dac_en_i(dac_en_i), .dac_data_i(dac_data_i), .dac_done_o(dac_done),
      .adc_en_i(adc_en_i), .adc_data_o(adc_data_o), .adc_done_o(adc_done),
      .busy_o(busy), .sclk_o(sclk), .mosi_o(mosi),
      .dac_cs_n_o(dac_cs_n), .adc_cs_n_o(adc_cs_n), .miso_i(miso)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ADC slave: MSB ready at cs_n fall, next bit after each sclk fall
   logic [DATA_W-1:0] slave_word = '0;
   logic [DATA_W-1:0] slave_shifted;
   int fall_cnt = 0;
   always @(negedge sclk or posedge adc_cs_n) begin
      if (adc_cs_n) fall_cnt <= 0;
      else          fall_cnt <= fall_cnt + 1;
   end
   always_comb begin
      slave_shifted = slave_word << fall_cnt;
      miso = 1'b0;
      if (!adc_cs_n) miso = slave_shifted[DATA_W-1];
   end

   // Monitor sampled mid-cycle
   int   dac_done_cnt = 0, adc_done_cnt = 0, dac_done_cyc = 0, adc_done_cyc = 0;
   int   rise_cnt = 0, viol = 0;
   logic sclk_prev = 1'b0;
   logic bits_at [256];
   always @(negedge clk) begin
      if (dac_done) begin dac_done_cnt <= dac_done_cnt + 1; dac_done_cyc <= cyc; end
      if (adc_done) begin adc_done_cnt <= adc_done_cnt + 1; adc_done_cyc <= cyc; end
      if ((!dac_cs_n && !adc_cs_n) || (dac_cs_n && mosi) || (dac_done && adc_done))
         viol <= viol + 1;
      if (sclk && !sclk_prev) begin
         bits_at[8'(rise_cnt)] <= mosi;
         rise_cnt <= rise_cnt + 1;
      end
      sclk_prev <= sclk;
   end

   int n_checks = 0, n_pass = 0;
   logic [DATA_W-1:0] last_adc_word = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_xfer(input bit is_dac, input logic [DATA_W-1:0] word,
                          input bit both, input bit poke_adc);
      int k, r0, d0, a0;
      bit got_done;
      logic [DATA_W-1:0] bits;
      if (!is_dac) slave_word = word;
      dac_data_i = is_dac ? word : DATA_W'($urandom);
      k  = cyc;
      r0 = rise_cnt;
      d0 = dac_done_cnt;
      a0 = adc_done_cnt;
      if (is_dac || both)  dac_en_i = 1'b1;
      if (!is_dac || both) adc_en_i = 1'b1;
      tick();
      check("busy_on_accept", 32'(busy), 1);
      dac_data_i = ~dac_data_i;
      got_done = 1'b0;
      for (int t = 0; t < LAT + 20 && !got_done; t++) begin
         if (poke_adc && t == 30) adc_en_i = 1'b1;
         if (is_dac ? (dac_done_cnt != d0) : (adc_done_cnt != a0)) got_done = 1'b1;
         else tick();
      end
      check("done_seen", 32'(got_done), 1);
      if (!got_done) return;
      if (is_dac) begin
         bits = '0;
         for (int i = 0; i < DATA_W; i++) bits = {bits[DATA_W-2:0], bits_at[8'(r0 + i)]};
         check("dac_latency", 32'(dac_done_cyc - k), LAT);
         check("mosi_word", 32'(bits), 32'(word));
      end else begin
         check("adc_latency", 32'(adc_done_cyc - k), LAT);
         check("adc_data_at_done", 32'(adc_data_o), 32'(word));
         last_adc_word = word;
      end
      check("sclk_rises", 32'(rise_cnt - r0), DATA_W);
      check("other_done_none", 32'(is_dac ? adc_done_cnt - a0 : dac_done_cnt - d0), 0);
      tick();
      check("busy_off", 32'(busy), 0);
      check("done_pulse_count", 32'(is_dac ? dac_done_cnt - d0 : adc_done_cnt - a0), 1);
      if (!is_dac) check("adc_data_held", 32'(adc_data_o), 32'(word));
      $display("xfer %s word=%03h start=%0d", is_dac ? "DAC" : "ADC", word, k);
   endtask

   initial begin
      int r0, d0, a0;
      bit reached;
      reset = 1'b1; dac_en_i = 1'b0; adc_en_i = 1'b0; dac_data_i = '0;
      repeat (5) tick();
      check("rst_dac_cs_n", 32'(dac_cs_n), 1);
      check("rst_adc_cs_n", 32'(adc_cs_n), 1);
      check("rst_sclk", 32'(sclk), 0);
      check("rst_mosi", 32'(mosi), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_dones", 32'({dac_done, adc_done}), 0);
      check("rst_adc_data", 32'(adc_data_o), 0);
      reset = 1'b0;
      tick();

      do_xfer(1'b1, 12'hABC, 1'b0, 1'b0);
      dac_en_i = 1'b0; tick();
      do_xfer(1'b0, 12'h789, 1'b0, 1'b0);
      adc_en_i = 1'b0; repeat (3) tick();
      check("adc_data_hold_later", 32'(adc_data_o), 32'h789);

      // simultaneous rises: DAC only, held adc_en must not retrigger
      do_xfer(1'b1, 12'h35A, 1'b1, 1'b0);
      dac_en_i = 1'b0;
      r0 = rise_cnt; d0 = dac_done_cnt; a0 = adc_done_cnt;
      repeat (150) tick();
      check("held_adc_no_xfer", 32'(rise_cnt - r0), 0);
      check("held_adc_no_done", 32'(adc_done_cnt - a0 + dac_done_cnt - d0), 0);
      adc_en_i = 1'b0; tick();
      do_xfer(1'b0, 12'h5C3, 1'b0, 1'b0);
      adc_en_i = 1'b0; tick();

      // adc rise during a DAC write is dropped; both levels held afterwards
      do_xfer(1'b1, 12'h0F1, 1'b0, 1'b1);
      r0 = rise_cnt; d0 = dac_done_cnt; a0 = adc_done_cnt;
      repeat (150) tick();
      check("held_both_no_xfer", 32'(rise_cnt - r0), 0);
      check("held_both_no_done", 32'(adc_done_cnt - a0 + dac_done_cnt - d0), 0);
      dac_en_i = 1'b0; adc_en_i = 1'b0; tick();

      repeat (8) begin
         do_xfer(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'b0, 1'b0);
         dac_en_i = 1'b0; adc_en_i = 1'b0;
         repeat ($urandom_range(1, 4)) tick();
      end

      // reset in the middle of an ADC read
      check("adc_data_before_abort", 32'(adc_data_o), 32'(last_adc_word));
      slave_word = 12'hC3A;
      r0 = rise_cnt; a0 = adc_done_cnt;
      adc_en_i = 1'b1;
      reached = 1'b0;
      for (int t = 0; t < 200 && !reached; t++) begin
         if (rise_cnt - r0 >= 7) reached = 1'b1;
         else tick();
      end
      check("reached_bit6", 32'(reached), 1);
      reset = 1'b1; adc_en_i = 1'b0;
      #1;
      check("abort_adc_cs_n", 32'(adc_cs_n), 1);
      check("abort_sclk", 32'(sclk), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_adc_data", 32'(adc_data_o), 0);
      repeat (3) tick();
      reset = 1'b0;
      repeat (120) tick();
      check("abort_no_adc_done", 32'(adc_done_cnt - a0), 0);
      do_xfer(1'b0, 12'h6D2, 1'b0, 1'b0);
      adc_en_i = 1'b0; tick();

      check("protocol_violations", 32'(viol), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
